// File: rtl/param_updown_counter.sv
// Purpose : parameterised up/down counter with load, clear, wrap or saturate, boundary pulse and sticky flags.
// Latency : count/bnd_evt/ovf/unf update one clk edge after the command; at_max/at_zero follow count combinationally.
// Backpr. : none; a command is accepted on every rising edge (priority clr > load > en).
// Ports   : clk, rst_n (async, active-low) | clr, load, load_val, en, up_dn (commands)
//           count, at_max, at_zero (state) | bnd_evt (1-cycle pulse), ovf, unf (sticky until clr/reset)
module param_updown_counter #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             bnd_evt,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_nxt;
  logic             evt_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == '0);

  always_comb begin
    count_nxt = count;
    evt_nxt   = 1'b0;
    ovf_nxt   = ovf;
    unf_nxt   = unf;
    if (clr) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;
    end else if (load) begin
      // Clamp keeps the count <= MAX_VAL invariant, so the boundary
      // compares below only ever need equality.
      count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          evt_nxt   = 1'b1;
          ovf_nxt   = 1'b1;
          count_nxt = SATURATE ? MAX_VAL : '0;
        end else begin
          count_nxt = count + ONE;
        end
      end else begin
        if (at_zero) begin
          evt_nxt   = 1'b1;
          unf_nxt   = 1'b1;
          count_nxt = SATURATE ? '0 : MAX_VAL;
        end else begin
          count_nxt = count - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      bnd_evt <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      count   <= count_nxt;
      bnd_evt <= evt_nxt;
      ovf     <= ovf_nxt;
      unf     <= unf_nxt;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Purpose : scoreboard bench for param_updown_counter across three configurations.
// Latency : expected state is queued per edge and compared 1 time unit after that edge.
// Backpr. : none; the monitor drains the queue on every rising edge.
module tb_param_updown_counter;

  localparam int N = 3;

  typedef struct {
    bit clr;
    bit load;
    bit en;
    bit up;
    int lv;
  } cmd_t;

  typedef struct {
    int idx;
    int phase;
    int cnt;
    bit amax;
    bit azero;
    bit evt;
    bit ovf;
    bit unf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr      [N];
  logic       load     [N];
  logic [7:0] load_val [N];
  logic       en       [N];
  logic       up_dn    [N];
  logic [7:0] count    [N];
  logic       at_max   [N];
  logic       at_zero  [N];
  logic       bnd_evt  [N];
  logic       ovf      [N];
  logic       unf      [N];

  // Configuration table: instance 0 wraps at 9, 1 saturates at 9, 2 wraps at 255 (defaults).
  int max_tab [N] = '{9, 9, 255};
  bit sat_tab [N] = '{1'b0, 1'b1, 1'b0};

  // Reference state
  int m_cnt [N];
  bit m_evt [N];
  bit m_ovf [N];
  bit m_unf [N];

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   phase = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(8), .MAX_VAL(8'd9), .SATURATE(1'b0)) u_wrap9 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .load(load[0]), .load_val(load_val[0]),
    .en(en[0]), .up_dn(up_dn[0]), .count(count[0]), .at_max(at_max[0]),
    .at_zero(at_zero[0]), .bnd_evt(bnd_evt[0]), .ovf(ovf[0]), .unf(unf[0]));

  param_updown_counter #(.WIDTH(8), .MAX_VAL(8'd9), .SATURATE(1'b1)) u_sat9 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .load(load[1]), .load_val(load_val[1]),
    .en(en[1]), .up_dn(up_dn[1]), .count(count[1]), .at_max(at_max[1]),
    .at_zero(at_zero[1]), .bnd_evt(bnd_evt[1]), .ovf(ovf[1]), .unf(unf[1]));

  param_updown_counter #(.WIDTH(8)) u_dflt (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]), .load(load[2]), .load_val(load_val[2]),
    .en(en[2]), .up_dn(up_dn[2]), .count(count[2]), .at_max(at_max[2]),
    .at_zero(at_zero[2]), .bnd_evt(bnd_evt[2]), .ovf(ovf[2]), .unf(unf[2]));

  function automatic exp_t snap(int j);
    exp_t e;
    e.idx   = j;
    e.phase = phase;
    e.cnt   = m_cnt[j];
    e.amax  = (m_cnt[j] == max_tab[j]);
    e.azero = (m_cnt[j] == 0);
    e.evt   = m_evt[j];
    e.ovf   = m_ovf[j];
    e.unf   = m_unf[j];
    return e;
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < N; j++) begin
      m_cnt[j] = 0;
      m_evt[j] = 0;
      m_ovf[j] = 0;
      m_unf[j] = 0;
    end
  endfunction

  // One rising edge of the behavioural counter.
  function automatic void model_apply(int j, cmd_t c);
    m_evt[j] = 0;
    if (c.clr) begin
      m_cnt[j] = 0;
      m_ovf[j] = 0;
      m_unf[j] = 0;
    end else if (c.load) begin
      m_cnt[j] = (c.lv > max_tab[j]) ? max_tab[j] : c.lv;
    end else if (c.en) begin
      if (c.up) begin
        if (m_cnt[j] == max_tab[j]) begin
          m_evt[j] = 1;
          m_ovf[j] = 1;
          m_cnt[j] = sat_tab[j] ? max_tab[j] : 0;
        end else begin
          m_cnt[j] = m_cnt[j] + 1;
        end
      end else begin
        if (m_cnt[j] == 0) begin
          m_evt[j] = 1;
          m_unf[j] = 1;
          m_cnt[j] = sat_tab[j] ? 0 : max_tab[j];
        end else begin
          m_cnt[j] = m_cnt[j] - 1;
        end
      end
    end
  endfunction

  task automatic compare(input string tag, input exp_t e);
    int k;
    k = e.idx;
    n_cmp++;
    if (count[k] !== e.cnt[7:0] || at_max[k] !== e.amax || at_zero[k] !== e.azero ||
        bnd_evt[k] !== e.evt || ovf[k] !== e.ovf || unf[k] !== e.unf) begin
      n_bad++;
      $display("FAIL %s inst%0d phase%0d: got cnt=%0d max=%b zero=%b evt=%b ovf=%b unf=%b, want cnt=%0d max=%b zero=%b evt=%b ovf=%b unf=%b",
               tag, k, e.phase, count[k], at_max[k], at_zero[k], bnd_evt[k], ovf[k], unf[k],
               e.cnt, e.amax, e.azero, e.evt, e.ovf, e.unf);
    end
  endtask

  task automatic drive(input int j, input cmd_t c);
    clr[j]      = c.clr;
    load[j]     = c.load;
    load_val[j] = c.lv[7:0];
    en[j]       = c.en;
    up_dn[j]    = c.up;
  endtask

  function automatic cmd_t mk(bit c, bit l, bit e, bit u, int v);
    cmd_t r;
    r.clr = c; r.load = l; r.en = e; r.up = u; r.lv = v;
    return r;
  endfunction

  // Issue one command to instance k (others idle) for the next edge and queue the expected state.
  task automatic step(input int k, input cmd_t c);
    cmd_t idle;
    idle = mk(0, 0, 0, 0, 0);
    @(negedge clk);
    for (int j = 0; j < N; j++) begin
      drive(j, (j == k) ? c : idle);
      model_apply(j, (j == k) ? c : idle);
      sb.push_back(snap(j));
    end
  endtask

  // Monitor: drain everything queued for the edge just taken.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        compare("edge", e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t idle;
    idle  = mk(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    for (int j = 0; j < N; j++) drive(j, idle);
    model_reset();
    #2;
    for (int j = 0; j < N; j++) compare("reset_state", snap(j));
    #1 rst_n = 1'b1;

    // Wrap at 9 counting up for 12 cycles.
    phase = 1;
    for (int i = 0; i < 12; i++) step(0, mk(0, 0, 1, 1, 0));

    // clr beats load and en, clears sticky ovf.
    phase = 2;
    step(0, mk(1, 1, 1, 1, 3));

    // Load clamp, then in-range load with no event.
    phase = 3;
    step(0, mk(0, 1, 0, 0, 200));
    step(0, mk(0, 1, 1, 0, 5));

    // Asynchronous reset between edges at count 7, with an up-count pending.
    phase = 4;
    step(0, mk(0, 1, 0, 0, 7));
    @(negedge clk);
    drive(0, mk(0, 0, 1, 1, 0));
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    for (int j = 0; j < N; j++) compare("async_reset", snap(j));
    #1 rst_n = 1'b1;
    drive(0, idle);
    #1;
    compare("reset_release", snap(0));
    step(0, idle);                      // first edge after release: stays 0
    step(0, mk(0, 0, 1, 1, 0));         // second edge: 1

    // Saturating instance counting down from 2.
    phase = 5;
    step(1, mk(0, 1, 0, 0, 2));
    for (int i = 0; i < 4; i++) step(1, mk(0, 0, 1, 0, 0));
    step(1, mk(0, 0, 1, 1, 0));         // leaves 0 again, unf stays sticky

    // Default configuration: 255 -> 0 up, 0 -> 255 down.
    phase = 6;
    step(2, mk(0, 1, 0, 0, 255));
    step(2, mk(0, 0, 1, 1, 0));
    step(2, mk(0, 0, 1, 0, 0));
    step(2, mk(0, 0, 0, 0, 0));

    // Randomised mix across all instances.
    phase = 7;
    for (int i = 0; i < 400; i++) begin
      cmd_t c;
      c.clr  = ($urandom_range(0, 24) == 0);
      c.load = ($urandom_range(0, 9) == 0);
      c.en   = ($urandom_range(0, 9) < 7);
      c.up   = ($urandom_range(0, 3) != 0) ^ (i >= 200);
      c.lv   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(250, 255)) : int'($urandom_range(0, 12));
      step(int'($urandom_range(0, N - 1)), c);
    end

    @(posedge clk);
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left in scoreboard, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
